timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Sequencing controller for the BCD countdown counter, which counts down from a preset of 0:30 (mode 0) or 1:00 (mode 1). It turns three push-button inputs (start/stop, mode, clear) and the counter's all-zero flag into the counter's enable, mode select and preload controls. It also drives a time-up alarm output. It sits between the board button inputs and the counter, and runs on the same slow clock, clk_out.

## Interface
- ALARM_CYCLES, 8: clk_out cycles the alarm stays active after time-up (≥1).
- BLINK_HALF, 1: clk_out cycles per alarm on/off phase (≥1).
- clk_out  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  start/stop button, asynchronous level, active-high.
- btn_mode  in  1  mode-toggle button, asynchronous level, active-high.
- btn_clear  in  1  clear button, asynchronous level, active-high.
- zero  in  1  counter reads 0:00 (all four digits zero), combinational from the counter.
- en  out  1  counter enable (count down).
- mode  out  1  preset select to counter: 0 = 0:30, 1 = 1:00.
- load  out  1  counter preload: counter holds its preset while high.
- alarm  out  1  blinking time-up indicator.
- state  out  2  current FSM state, for LEDs and debug.

## Operation
- Each button passes through its own two-flop synchronizer and a rising-edge detector. The result is a one-cycle event per press: ev_start, ev_mode, ev_clear.
- A held button produces exactly one event.
- FSM states:
  - IDLE = 0. Outputs: en=0, load=1. Counter shows its preset.
  - RUN = 1. Outputs: en=1, load=0.
  - PAUSE = 2. Outputs: en=0, load=0. Counter value is frozen.
  - DONE = 3. Outputs: en=0, load=0. Alarm sequence runs.
- Transitions. Within a state, priority is highest first.
  - IDLE: ev_clear → IDLE. Otherwise ev_start → RUN. Otherwise ev_mode toggles mode_q and stays in IDLE.
  - RUN: ev_clear → IDLE. Otherwise zero → DONE. Otherwise ev_start → PAUSE.
  - PAUSE: ev_clear → IDLE. Otherwise ev_start → RUN.
  - DONE: ev_clear or ev_start → IDLE.
- ev_mode is ignored in every state except IDLE. mode is stable for the whole of RUN, PAUSE and DONE.
- ev_start together with ev_mode in IDLE: the FSM goes to RUN and mode does not toggle.
- Entering RUN while zero=1 (not possible with legal presets) goes to DONE on the next cycle.
- Alarm behaviour:
  - On entry to DONE, alarm_cnt clears and the blink phase starts high.
  - alarm = phase AND (alarm_cnt < ALARM_CYCLES).
  - phase toggles every BLINK_HALF cycles.
  - alarm_cnt increments each DONE cycle and saturates at ALARM_CYCLES.
  - Outside DONE, alarm=0.
- Once the alarm has expired, the FSM stays in DONE showing 0:00 until ev_clear or ev_start.

## Timing
- Reset values: state=IDLE, en=0, load=1, mode=0, alarm=0. Synchronizers, edge detectors and counters all clear to 0.
- All outputs are registered or decoded directly from registers. None is combinational from btn_* or zero.
- Button latency:
  - A button first sampled high at edge k gives its event during cycle k+2.
  - The resulting state/output change is visible after edge k+3.
- Zero latency: zero high in RUN during cycle j → after edge j+1, state=DONE and en=0.
- With en=0 from edge j+1, the counter performs no further decrement. It already holds 0:00, and the counter itself saturates at zero.
- Alarm timing: alarm=1 in the first DONE cycle. It is high for exactly ceil-count phases within ALARM_CYCLES cycles, then stays 0.
- Asynchronous reset mid-RUN or mid-DONE forces the reset values immediately. load=1 then restores the counter preset on the next clock.

## Structure
- timer_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - the mode constants MODE_30S = 0 and MODE_60S = 1.
- Sub-module btn_sync_edge: two-flop synchronizer plus rising-edge pulse, asynchronous active-low reset. It is instantiated three times.
- The FSM, mode register and alarm counter/blink logic live in timer_ctrl itself.

## Test plan
- Reset release, then btn_start held 5 cycles → exactly one transition: state=RUN, en=1, load=0, three edges after the first sampled high.
- In IDLE, two btn_mode presses → mode 0→1→0 and load=1 throughout. A mode press in RUN → mode unchanged.
- RUN, start press → PAUSE with en=0. Start press again → RUN with en=1. The counter value on the model is unchanged across the pause.
- RUN with zero driven high at cycle j → state=DONE and en=0 after edge j+1.
  - With ALARM_CYCLES=8, BLINK_HALF=1: alarm pattern 1,0,1,0,1,0,1,0, then 0 forever, and state stays DONE.
- DONE, clear press → IDLE, load=1, alarm=0.
  - ev_clear and ev_start in the same cycle during RUN → IDLE.
  - zero=1 together with ev_start in RUN → DONE.
- reset_n pulsed low mid-RUN, asynchronous to the clock → outputs return to reset values before the next clk_out edge.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer controller.
// State encoding is exported on the state port, so the values are fixed.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_30S = 1'b0;
    localparam logic MODE_60S = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered rising-edge detector that emits a single-cycle event per press.
module btn_sync_edge (
    input  logic clk_out,
    input  logic reset_n,
    input  logic btn,
    output logic ev
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            ev      <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            ev      <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the BCD countdown counter: button handling,
// run/pause/done FSM, preset mode register and blinking time-up alarm.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int ALARM_CYCLES = 8,
    parameter int BLINK_HALF   = 1
) (
    input  logic       clk_out,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_clear,
    input  logic       zero,
    output logic       en,
    output logic       mode,
    output logic       load,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int CNT_W = width_for(ALARM_CYCLES);
    localparam int BLK_W = width_for(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] ALARM_MAX  = CNT_W'(ALARM_CYCLES);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);

    logic ev_start;
    logic ev_mode;
    logic ev_clear;

    btn_sync_edge u_sync_start (
        .clk_out (clk_out),
        .reset_n (reset_n),
        .btn     (btn_start),
        .ev      (ev_start)
    );

    btn_sync_edge u_sync_mode (
        .clk_out (clk_out),
        .reset_n (reset_n),
        .btn     (btn_mode),
        .ev      (ev_mode)
    );

    btn_sync_edge u_sync_clear (
        .clk_out (clk_out),
        .reset_n (reset_n),
        .btn     (btn_clear),
        .ev      (ev_clear)
    );

    state_e             state_q;
    state_e             state_nxt;
    logic               mode_nxt;
    logic [CNT_W-1:0]   alarm_cnt;
    logic [BLK_W-1:0]   blink_cnt;
    logic               phase;

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode;
        case (state_q)
            ST_IDLE: begin
                if (ev_clear)      state_nxt = ST_IDLE;
                else if (ev_start) state_nxt = ST_RUN;
                else if (ev_mode)  mode_nxt  = ~mode;
            end
            ST_RUN: begin
                if (ev_clear)      state_nxt = ST_IDLE;
                else if (zero)     state_nxt = ST_DONE;
                else if (ev_start) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (ev_clear)      state_nxt = ST_IDLE;
                else if (ev_start) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (ev_clear || ev_start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counter controls are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            en        <= 1'b0;
            load      <= 1'b1;
            mode      <= MODE_30S;
            alarm_cnt <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            en      <= (state_nxt == ST_RUN);
            load    <= (state_nxt == ST_IDLE);
            mode    <= mode_nxt;

            if (state_nxt == ST_DONE && state_q != ST_DONE) begin
                alarm_cnt <= '0;
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (state_q == ST_DONE) begin
                if (alarm_cnt != ALARM_MAX) alarm_cnt <= alarm_cnt + 1'b1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Decoded purely from registers; stale phase/count outside DONE is masked.
    assign alarm = (state_q == ST_DONE) && phase && (alarm_cnt < ALARM_MAX);
    assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: per-cycle stimulus rows carry their
// expected {state,en,load,mode,alarm} into a scoreboard queue.
module tb_timer_ctrl;

    localparam int ALARM_CYCLES = 8;
    localparam int BLINK_HALF   = 1;

    // Expected output vectors: {state[1:0], en, load, mode, alarm}
    localparam logic [5:0] I0 = 6'b00_0_1_0_0;
    localparam logic [5:0] I1 = 6'b00_0_1_1_0;
    localparam logic [5:0] R0 = 6'b01_1_0_0_0;
    localparam logic [5:0] R1 = 6'b01_1_0_1_0;
    localparam logic [5:0] P0 = 6'b10_0_0_0_0;
    localparam logic [5:0] D0 = 6'b11_0_0_0_0;
    localparam logic [5:0] D1 = 6'b11_0_0_0_1;

    logic       clk_out   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_mode  = 1'b0;
    logic       btn_clear = 1'b0;
    logic       zero      = 1'b0;
    logic       en;
    logic       mode;
    logic       load;
    logic       alarm;
    logic [1:0] state;

    always #5 clk_out = ~clk_out;

    timer_ctrl #(
        .ALARM_CYCLES (ALARM_CYCLES),
        .BLINK_HALF   (BLINK_HALF)
    ) dut (
        .clk_out   (clk_out),
        .reset_n   (reset_n),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_clear (btn_clear),
        .zero      (zero),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .alarm     (alarm),
        .state     (state)
    );

    typedef struct {
        string      name;
        logic       s;
        logic       m;
        logic       c;
        logic       z;
        logic [5:0] exp;
    } row_t;

    row_t sb[$];
    row_t r;
    int   checks    = 0;
    int   errors    = 0;
    int   cnt_model = 30;
    int   cnt_pause = 0;

    function automatic logic [5:0] obs();
        return {state, en, load, mode, alarm};
    endfunction

    function automatic void add(input string n, input logic s, input logic m,
                                input logic c, input logic z, input logic [5:0] e);
        sb.push_back('{name: n, s: s, m: m, c: c, z: z, exp: e});
    endfunction

    // Queue a start press (one cycle high) leading into RUN from IDLE.
    function automatic void add_start(input logic [5:0] idle_v, input logic [5:0] run_v);
        add("start_wait", 1, 0, 0, 0, idle_v);
        add("start_wait", 0, 0, 0, 0, idle_v);
        add("start_wait", 0, 0, 0, 0, idle_v);
        add("start_run",  0, 0, 0, 0, run_v);
    endfunction

    // Drive one row at the falling edge, advance the counter model with the
    // controls the counter sees at the coming rising edge, then wait to sample.
    task automatic apply(input row_t row);
        btn_start = row.s;
        btn_mode  = row.m;
        btn_clear = row.c;
        zero      = row.z;
        if (load)                       cnt_model = mode ? 60 : 30;
        else if (en && cnt_model > 0)   cnt_model = cnt_model - 1;
        @(posedge clk_out);
        @(negedge clk_out);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_out);
        @(negedge clk_out);
        checks++;
        if (obs() !== I0) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", obs(), I0);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 5; i++) add(i < 3 ? "held_wait" : "held_run", 1, 0, 0, 0, i < 3 ? I0 : R0);
        for (int i = 0; i < 3; i++) add("held_once", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 1, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_mode();
        add("mode_up",   0, 1, 0, 0, I0);
        add("mode_up",   0, 0, 0, 0, I0);
        add("mode_up",   0, 0, 0, 0, I0);
        add("mode_up",   0, 0, 0, 0, I1);
        add("mode_up",   0, 0, 0, 0, I1);
        add("mode_down", 0, 1, 0, 0, I1);
        add("mode_down", 0, 0, 0, 0, I1);
        add("mode_down", 0, 0, 0, 0, I1);
        add("mode_down", 0, 0, 0, 0, I0);
        add("mode_down", 0, 0, 0, 0, I0);
        add_start(I0, R0);
        add("mode_in_run", 0, 1, 0, 0, R0);
        for (int i = 0; i < 5; i++) add("mode_in_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 1, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_pause();
        add_start(I0, R0);
        add("run", 0, 0, 0, 0, R0);
        add("to_pause", 1, 0, 0, 0, R0);
        add("to_pause", 0, 0, 0, 0, R0);
        add("to_pause", 0, 0, 0, 0, R0);
        add("to_pause", 0, 0, 0, 0, P0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
        cnt_pause = cnt_model;
        add("paused",    0, 0, 0, 0, P0);
        add("paused",    0, 0, 0, 0, P0);
        add("to_resume", 1, 0, 0, 0, P0);
        add("to_resume", 0, 0, 0, 0, P0);
        add("to_resume", 0, 0, 0, 0, P0);
        add("to_resume", 0, 0, 0, 0, R0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
        checks++;
        if (cnt_model != cnt_pause || cnt_model >= 30) begin
            errors++;
            $display("FAIL pause_hold: counter got %0d required %0d (below 30)", cnt_model, cnt_pause);
        end
        add("clear_run", 0, 0, 1, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, R0);
        add("clear_run", 0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_zero_alarm();
        add_start(I0, R0);
        add("run", 0, 0, 0, 0, R0);
        add("zero_done", 0, 0, 0, 1, D1);
        for (int i = 1; i < 8; i++) add("alarm_blink", 0, 0, 0, 1, (i % 2 == 0) ? D1 : D0);
        for (int i = 0; i < 5; i++) add("alarm_expired", 0, 0, 0, 1, D0);
        add("clear_done", 0, 0, 1, 1, D0);
        add("clear_done", 0, 0, 0, 1, D0);
        add("clear_done", 0, 0, 0, 1, D0);
        add("clear_done", 0, 0, 0, 1, I0);
        add("idle_after", 0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        // clear and start events in the same RUN cycle: clear wins
        add_start(I0, R0);
        add("clear_start", 1, 0, 1, 0, R0);
        add("clear_start", 0, 0, 0, 0, R0);
        add("clear_start", 0, 0, 0, 0, R0);
        add("clear_start", 0, 0, 0, 0, I0);
        // zero and start event in the same RUN cycle: zero wins
        add_start(I0, R0);
        add("zero_start", 1, 0, 0, 0, R0);
        add("zero_start", 0, 0, 0, 0, R0);
        add("zero_start", 0, 0, 0, 0, R0);
        add("zero_start", 0, 0, 0, 1, D1);
        add("zero_start", 0, 0, 0, 1, D0);
        add("start_done", 1, 0, 0, 1, D1);
        add("start_done", 0, 0, 0, 1, D0);
        add("start_done", 0, 0, 0, 1, D1);
        add("start_done", 0, 0, 0, 1, I0);
        add("start_done", 0, 0, 0, 0, I0);
        // start and mode together in IDLE: run without toggling mode
        add("start_mode", 1, 1, 0, 0, I0);
        add("start_mode", 0, 0, 0, 0, I0);
        add("start_mode", 0, 0, 0, 0, I0);
        add("start_mode", 0, 0, 0, 0, R0);
        add("start_mode", 0, 0, 0, 0, R0);
        add("clear_run",  0, 0, 1, 0, R0);
        add("clear_run",  0, 0, 0, 0, R0);
        add("clear_run",  0, 0, 0, 0, R0);
        add("clear_run",  0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_async_reset();
        add("mode_up", 0, 1, 0, 0, I0);
        add("mode_up", 0, 0, 0, 0, I0);
        add("mode_up", 0, 0, 0, 0, I0);
        add("mode_up", 0, 0, 0, 0, I1);
        add_start(I1, R1);
        add("run_60", 0, 0, 0, 0, R1);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
        @(posedge clk_out);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== I0) begin
            errors++;
            $display("FAIL async_reset: got state/en/load/mode/alarm=%b required %b", obs(), I0);
        end
        @(posedge clk_out);
        @(negedge clk_out);
        checks++;
        if (obs() !== I0) begin
            errors++;
            $display("FAIL reset_hold: got state/en/load/mode/alarm=%b required %b", obs(), I0);
        end
        reset_n = 1'b1;
        add("after_reset", 0, 0, 0, 0, I0);
        add("after_reset", 0, 0, 0, 0, I0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            apply(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL %s: got state/en/load/mode/alarm=%b required %b", r.name, obs(), r.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_start_held();
        test_mode();
        test_pause();
        test_zero_alarm();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
